// File: rtl/mem_sched.sv
// mem_sched: shares one data-memory port and the rs/rd register-file read
// ports among the instruction slots. One ready LB/SB slot at a time is granted
// round-robin, its operands are read, a req/ack memory transaction is run
// (with a timeout), then the loaded byte is written back (LB) and the slot is
// stamped complete.
//
// Ports:
//   clk, reset             clock (rising edge); async active-low reset
//   reg_start_flat         3-bit state per slot, 3'b010 = runnable
//   reg_out_flat           88-bit instruction per slot
//   stamp_flat, stamp_in   new slot state and one-hot write strobe (DONE only)
//   reg_search_out10/11    rs / rd read addresses (ISSUE only)
//   reg_out10/11           rs / rd read data, combinational
//   reg_search_in10,
//   reg_in10, reg_in10_start  load writeback (DONE, LB only)
//   mem_req/we/addr/be/wdata  memory request, held for the whole WAIT phase
//   mem_ack, mem_rdata     memory completion and load data
//   busy                   not in IDLE
//   timeout_err            sticky, set when a transaction is abandoned
module mem_sched #(
  parameter int SLOTS   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3*SLOTS-1:0]  reg_start_flat,
  input  logic [88*SLOTS-1:0] reg_out_flat,
  output logic [3*SLOTS-1:0]  stamp_flat,
  output logic [SLOTS-1:0]    stamp_in,
  output logic [4:0]          reg_search_out10,
  input  logic [31:0]         reg_out10,
  output logic [4:0]          reg_search_out11,
  input  logic [31:0]         reg_out11,
  output logic [4:0]          reg_search_in10,
  output logic [31:0]         reg_in10,
  output logic                reg_in10_start,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [3:0]          mem_be,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ack,
  input  logic [31:0]         mem_rdata,
  output logic                busy,
  output logic                timeout_err
);

  localparam logic [5:0] OP_LB  = 6'b001100;
  localparam logic [5:0] OP_SB  = 6'b001101;
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       rr_ptr;
  logic [7:0]       wait_cnt;
  logic [SLOTS-1:0] elig;
  logic             grant_vld;
  logic [2:0]       grant_idx;
  logic [2:0]       scan_idx;
  logic [87:0]      gnt_instr;

  // Fields latched at grant; the slot may change underneath us afterwards.
  logic [2:0]       slot_p0;
  logic             sb_p0;
  logic [4:0]       rs_p0;
  logic [4:0]       rd_p0;
  logic             b2_p0;
  logic             b0_p0;
  logic [31:0]      addr_p1;
  logic [3:0]       be_p1;
  logic             we_p1;
  logic [31:0]      wdata_p1;
  logic [7:0]       ld_byte_p2;

  logic             wait_expired;
  logic             unused_bits;

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      elig[i] = (reg_start_flat[3*i +: 3] == 3'b010) &&
                ((reg_out_flat[88*i+82 +: 6] == OP_LB) ||
                 (reg_out_flat[88*i+82 +: 6] == OP_SB));
    end
  end

  // Scan from the farthest offset down so the slot closest to rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = SLOTS-1; k >= 0; k--) begin
      scan_idx = rr_ptr + 3'(k);
      if (elig[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign gnt_instr    = reg_out_flat[88*grant_idx +: 88];
  assign wait_expired = (state == S_WAIT) && !mem_ack && (wait_cnt == TO_CNT);
  assign busy         = (state != S_IDLE);

  // Instruction and read-data bits this block never looks at.
  assign unused_bits = ^{gnt_instr[87:83], gnt_instr[76:72], gnt_instr[66:3],
                         gnt_instr[1], reg_out11[31:8]};

  always_comb begin
    state_nxt        = state;
    stamp_flat       = '0;
    stamp_in         = '0;
    reg_search_out10 = '0;
    reg_search_out11 = '0;
    reg_search_in10  = '0;
    reg_in10         = '0;
    reg_in10_start   = 1'b0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_be           = '0;
    mem_wdata        = '0;
    unique case (state)
      S_IDLE: begin
        if (grant_vld) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        reg_search_out10 = rs_p0;
        reg_search_out11 = rd_p0;
        state_nxt        = S_WAIT;
      end
      S_WAIT: begin
        // Outputs come straight from registers so they stay stable until ack
        // and vanish the instant reset forces the state back to IDLE.
        mem_req   = 1'b1;
        mem_we    = we_p1;
        mem_addr  = addr_p1;
        mem_be    = be_p1;
        mem_wdata = wdata_p1;
        if (mem_ack)           state_nxt = S_DONE;
        else if (wait_expired) state_nxt = S_IDLE;
      end
      S_DONE: begin
        stamp_in[slot_p0]          = 1'b1;
        stamp_flat[3*slot_p0 +: 3] = {b2_p0, 1'b1, b0_p0};
        if (!sb_p0) begin
          reg_in10_start  = 1'b1;
          reg_search_in10 = rd_p0;
          reg_in10        = {24'd0, ld_byte_p2};
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_ISSUE)     wait_cnt <= 8'd1;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 8'd1;
      if (state == S_DONE) rr_ptr <= slot_p0 + 3'd1;
      if (wait_expired) begin
        timeout_err <= 1'b1;
        rr_ptr      <= slot_p0 + 3'd1;
      end
    end
  end

  // ---- p0: grant, latch slot fields ----
  always_ff @(posedge clk) begin
    if (state == S_IDLE && grant_vld) begin
      slot_p0 <= grant_idx;
      sb_p0   <= gnt_instr[82];
      rs_p0   <= gnt_instr[81:77];
      rd_p0   <= gnt_instr[71:67];
      b2_p0   <= gnt_instr[2];
      b0_p0   <= gnt_instr[0];
    end
  end

  // ---- p1: operand read, build memory request ----
  always_ff @(posedge clk) begin
    if (state == S_ISSUE) begin
      addr_p1  <= reg_out10;
      be_p1    <= 4'b0001 << reg_out10[1:0];
      we_p1    <= sb_p0;
      wdata_p1 <= sb_p0 ? {4{reg_out11[7:0]}} : 32'd0;
    end
  end

  // ---- p2: capture load byte on ack ----
  always_ff @(posedge clk) begin
    if (state == S_WAIT && mem_ack) begin
      ld_byte_p2 <= mem_rdata[8*addr_p1[1:0] +: 8];
    end
  end

endmodule

// File: tb/tb_mem_sched.sv
module tb_mem_sched;
  localparam int SLOTS   = 8;
  localparam int TIMEOUT = 16;
  localparam logic [5:0] LB = 6'b001100;
  localparam logic [5:0] SB = 6'b001101;

  logic         clk = 1'b0;
  logic         reset;
  logic [23:0]  reg_start_flat;
  logic [703:0] reg_out_flat;
  logic [23:0]  stamp_flat;
  logic [7:0]   stamp_in;
  logic [4:0]   reg_search_out10, reg_search_out11, reg_search_in10;
  logic [31:0]  reg_out10, reg_out11, reg_in10;
  logic         reg_in10_start;
  logic         mem_req, mem_we, mem_ack, busy, timeout_err;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_be;

  logic [31:0]  rf  [32];
  logic [2:0]   st  [8];
  logic [87:0]  ins [8];
  int           rr_m;
  logic         terr_m;
  int           n_vec = 0;
  int           n_err = 0;

  mem_sched #(.SLOTS(SLOTS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .reg_start_flat(reg_start_flat), .reg_out_flat(reg_out_flat),
    .stamp_flat(stamp_flat), .stamp_in(stamp_in),
    .reg_search_out10(reg_search_out10), .reg_out10(reg_out10),
    .reg_search_out11(reg_search_out11), .reg_out11(reg_out11),
    .reg_search_in10(reg_search_in10), .reg_in10(reg_in10),
    .reg_in10_start(reg_in10_start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Register file: combinational reads.
  assign reg_out10 = rf[reg_search_out10];
  assign reg_out11 = rf[reg_search_out11];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pack();
    for (int i = 0; i < SLOTS; i++) begin
      reg_start_flat[3*i +: 3]  = st[i];
      reg_out_flat[88*i +: 88]  = ins[i];
    end
  endtask

  function automatic logic [87:0] make_ins(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rd);
    logic [87:0] v;
    v[31:0]  = $urandom;
    v[63:32] = $urandom;
    v[87:64] = 24'($urandom);
    v[87:82] = op;
    v[81:77] = rs;
    v[71:67] = rd;
    return v;
  endfunction

  task automatic set_slot(input int i, input logic [5:0] op, input logic [4:0] rs,
                          input logic [4:0] rd);
    ins[i] = make_ins(op, rs, rd);
    st[i]  = 3'b010;
    pack();
  endtask

  task automatic clear_slots();
    for (int i = 0; i < SLOTS; i++) st[i] = 3'b000;
    pack();
  endtask

  task automatic rand_slots();
    for (int i = 0; i < SLOTS; i++) begin
      int r;
      logic [5:0] op;
      r  = $urandom_range(0, 9);
      op = (r < 4) ? LB : (r < 8) ? SB : 6'($urandom);
      ins[i] = make_ins(op, 5'($urandom), 5'($urandom));
      st[i]  = ($urandom_range(0, 3) != 0) ? 3'b010 : 3'($urandom);
    end
    pack();
  endtask

  // Reference: a slot is eligible when runnable and LB/SB; the grant is the
  // first eligible slot at or after the round-robin pointer.
  function automatic bit elig_m(input int i);
    return (st[i] == 3'b010) && ((ins[i][87:82] == LB) || (ins[i][87:82] == SB));
  endfunction

  function automatic int pick_m();
    int j;
    for (int k = 0; k < SLOTS; k++) begin
      j = (rr_m + k) % SLOTS;
      if (elig_m(j)) return j;
    end
    return -1;
  endfunction

  // Runs one scheduling attempt from an IDLE negedge. delay = WAIT cycle on
  // which ack is given (> TIMEOUT means never).
  task automatic do_txn(input int delay, input bit scramble, input int rearm,
                        input logic [31:0] rdat);
    int          s;
    logic [87:0] saved;
    logic [2:0]  st_orig;
    logic [4:0]  rs, rd;
    logic        sb;
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic [7:0]  byte_e;
    logic [23:0] sf;
    bit          acked;
    s = pick_m();
    if (s < 0) begin
      chk("idle_busy", 64'(busy), 64'(0));
      step();
      chk("idle_stay", 64'(busy), 64'(0));
      return;
    end
    chk("pre_busy", 64'(busy), 64'(0));
    saved   = ins[s];
    st_orig = st[s];
    rs      = saved[81:77];
    rd      = saved[71:67];
    sb      = (saved[87:82] == SB);
    a       = rf[rs];
    be      = 4'b0001 << a[1:0];
    wd      = sb ? {4{rf[rd][7:0]}} : 32'd0;

    step();  // ISSUE
    chk("issue_busy", 64'(busy), 64'(1));
    chk("issue_rs", 64'(reg_search_out10), 64'(rs));
    chk("issue_rd", 64'(reg_search_out11), 64'(rd));
    chk("issue_req", 64'(mem_req), 64'(0));
    if (scramble) begin
      ins[s] = make_ins(6'($urandom), 5'($urandom), 5'($urandom));
      st[s]  = 3'($urandom);
      pack();
    end

    acked = 1'b0;
    for (int w = 1; w <= TIMEOUT; w++) begin
      step();  // WAIT cycle w
      chk("wait_req", 64'(mem_req), 64'(1));
      chk("wait_addr", 64'(mem_addr), 64'(a));
      chk("wait_be", 64'(mem_be), 64'(be));
      chk("wait_we", 64'(mem_we), 64'(sb));
      chk("wait_wdata", 64'(mem_wdata), 64'(wd));
      chk("wait_stamp", 64'(stamp_in), 64'(0));
      if (w == 1 && rearm >= 0 && rearm != s) begin
        st[rearm] = 3'b010;
        pack();
      end
      if (w == delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rdat;
        acked     = 1'b1;
        break;
      end
    end
    step();
    mem_ack   = 1'b0;
    mem_rdata = $urandom;

    if (acked) begin
      byte_e = rdat[8*a[1:0] +: 8];
      sf = '0;
      sf[3*s +: 3] = {saved[2], 1'b1, saved[0]};
      chk("done_req", 64'(mem_req), 64'(0));
      chk("done_busy", 64'(busy), 64'(1));
      chk("done_stamp_in", 64'(stamp_in), 64'(8'b1 << s));
      chk("done_stamp_flat", 64'(stamp_flat), 64'(sf));
      chk("done_wb_strobe", 64'(reg_in10_start), 64'(!sb));
      if (!sb) begin
        chk("done_wb_addr", 64'(reg_search_in10), 64'(rd));
        chk("done_wb_data", 64'(reg_in10), 64'({24'd0, byte_e}));
      end
      // Upstream updates the slot state on the DONE edge.
      ins[s] = saved;
      st[s]  = sf[3*s +: 3];
      pack();
      rr_m = (s + 1) % SLOTS;
      step();
      chk("post_busy", 64'(busy), 64'(0));
      chk("post_stamp", 64'(stamp_in), 64'(0));
      chk("post_wb", 64'(reg_in10_start), 64'(0));
    end else begin
      chk("to_req", 64'(mem_req), 64'(0));
      chk("to_busy", 64'(busy), 64'(0));
      chk("to_stamp", 64'(stamp_in), 64'(0));
      chk("to_wb", 64'(reg_in10_start), 64'(0));
      terr_m = 1'b1;
      ins[s] = saved;
      st[s]  = st_orig;
      pack();
      rr_m = (s + 1) % SLOTS;
    end
    chk("timeout_err", 64'(timeout_err), 64'(terr_m));
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    rr_m   = 0;
    terr_m = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // Reset asserted between clock edges in the second WAIT cycle.
  task automatic reset_mid();
    int s;
    s = pick_m();
    if (s < 0) begin
      chk("rstmid_setup", 64'(0), 64'(1));
      return;
    end
    step();
    step();
    step();
    chk("rstmid_pre_req", 64'(mem_req), 64'(1));
    #2 reset = 1'b0;
    #1;
    chk("rstmid_req", 64'(mem_req), 64'(0));
    chk("rstmid_busy", 64'(busy), 64'(0));
    chk("rstmid_stamp", 64'(stamp_in), 64'(0));
    chk("rstmid_terr", 64'(timeout_err), 64'(0));
    rr_m   = 0;
    terr_m = 1'b0;
    @(negedge clk);
    chk("rstmid_wb", 64'(reg_in10_start), 64'(0));
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    rr_m      = 0;
    terr_m    = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int i = 0; i < SLOTS; i++) ins[i] = make_ins(6'd0, 5'd0, 5'd0);
    clear_slots();
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req", 64'(mem_req), 64'(0));
    chk("rst_stamp_in", 64'(stamp_in), 64'(0));
    chk("rst_stamp_flat", 64'(stamp_flat), 64'(0));
    chk("rst_wb", 64'(reg_in10_start), 64'(0));
    chk("rst_terr", 64'(timeout_err), 64'(0));
    reset = 1'b1;
    step();

    // Single LB: slot 3, rs=r2 -> 0x1002 (byte lane 2), rd=r5.
    rf[2] = 32'h0000_1002;
    set_slot(3, LB, 5'd2, 5'd5);
    do_txn(1, 1'b0, -1, 32'hAABB_CCDD);

    // Single SB: slot 0, rs=r1 -> 0x2003, rd=r4 -> 0x1234_5678.
    clear_slots();
    rf[1] = 32'h0000_2003;
    rf[4] = 32'h1234_5678;
    set_slot(0, SB, 5'd1, 5'd4);
    do_txn(1, 1'b0, -1, $urandom);

    // Round-robin 1, 4, 6 from reset; slot 1 re-armed while 6 runs; 5-cycle stall.
    clear_slots();
    do_reset();
    set_slot(1, LB, 5'($urandom), 5'($urandom));
    set_slot(4, SB, 5'($urandom), 5'($urandom));
    set_slot(6, LB, 5'($urandom), 5'($urandom));
    do_txn(1, 1'b0, -1, $urandom);
    do_txn(5, 1'b1, -1, $urandom);
    do_txn(2, 1'b0, 1, $urandom);
    do_txn(1, 1'b0, -1, $urandom);
    do_txn(1, 1'b0, -1, $urandom);

    // Timeout on slot 2; the next grant moves on to slot 5.
    clear_slots();
    set_slot(2, LB, 5'($urandom), 5'($urandom));
    set_slot(5, SB, 5'($urandom), 5'($urandom));
    rr_m = 2;
    do_reset();
    rr_m = 0;
    do_txn(TIMEOUT + 1, 1'b0, -1, $urandom);
    do_txn(3, 1'b0, -1, $urandom);
    do_txn(1, 1'b0, -1, $urandom);

    // Asynchronous reset in WAIT; afterwards grants restart from slot 0.
    clear_slots();
    set_slot(5, LB, 5'($urandom), 5'($urandom));
    set_slot(0, SB, 5'($urandom), 5'($urandom));
    rr_m = 4;
    do_reset();
    rr_m = 0;
    st[0] = 3'b000;
    pack();
    do_txn(1, 1'b0, -1, $urandom);
    set_slot(0, SB, 5'($urandom), 5'($urandom));
    reset_mid();
    do_txn(1, 1'b0, -1, $urandom);

    // Randomized traffic.
    for (int t = 0; t < 70; t++) begin
      int dly;
      int ra;
      if (pick_m() < 0 || $urandom_range(0, 7) == 0) rand_slots();
      if ($urandom_range(0, 3) == 0) for (int i = 0; i < 32; i++) rf[i] = $urandom;
      dly = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : $urandom_range(1, 6);
      ra  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
      do_txn(dly, 1'($urandom_range(0, 1)), ra, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
